sc_window_decoder: RTL and testbench
====================================

// Module: sc_window_decoder
// PURPOSE
//  Windowed stochastic-to-binary decoder for the output of stanh (or any SC bitstream).
//  On a start request it drops SKIP settling cycles, then counts the ones in x over
//  exactly 2^N clocks. It presents the count on q with a valid/ready handshake.
//  Sits directly downstream of stanh; unlike dru it gives one framed, acknowledged result per window.
// PARAMETERS
//  N     10  result width; window length = 2^N cycles (N >= 2)
//  SKIP  0   warm-up cycles discarded after start, for upstream FSM settling (0..255)
// PORTS
//  clk      in   1  rising-edge clock
//  rst      in   1  synchronous, active-high reset
//  x        in   1  stochastic bitstream, sampled every clk in ACC
//  start    in   1  request a new window; honoured in IDLE, or in HOLD when q_ready=1
//  busy     out  1  high in WARM and ACC
//  q        out  N  decoded value, valid while q_valid=1
//  q_valid  out  1  result available
//  q_ready  in   1  consumer accepts q when q_valid & q_ready at a rising edge
// BEHAVIOUR
//  Reset: on any edge with rst=1 -> state IDLE; q=0, q_valid=0, busy=0; counters cleared.
//   Same outcome mid-window: the partial count is discarded and there is no output.
//  FSM states: IDLE, WARM, ACC, HOLD.
//   IDLE: start=1 -> WARM if SKIP>0, else ACC. Ones-counter and window-counter are cleared on entry.
//   WARM: stays SKIP cycles with x ignored, then -> ACC.
//   ACC: x is added to the ones-counter on each of 2^N consecutive edges. After the 2^N-th sample -> HOLD.
//   HOLD: q_valid=1 and q stays stable until the handshake.
//    q_ready=1 & start=0 -> IDLE.
//    q_ready=1 & start=1 -> WARM/ACC directly (back-to-back, no idle bubble).
//    q_ready=0 -> stays in HOLD; start is ignored.
//  start is ignored in WARM and ACC; it is a level sampled only in IDLE/HOLD.
//  Timing (SKIP=0): start seen at edge k. x is sampled at edges k+1..k+2^N.
//   q_valid rises after edge k+2^N (visible in the following cycle).
//  Arithmetic: the ones-counter is N+1 bits (range 0..2^N). The window counter is N bits
//   and wraps at 2^N to signal end-of-window.
//  q (unsigned) = min(ones, 2^N-1), so the all-ones stream saturates to 2^N-1.
//  q and q_valid are registered outputs; there is no combinational path from x/start/q_ready.
// CONFIGURATION
//  Macro SC_BIPOLAR_EN:
//   defined     -> q is N-bit two's complement bipolar value = ones - 2^(N-1),
//                  saturated to [-2^(N-1), 2^(N-1)-1]. Matches the stanh bipolar encoding.
//   not defined -> unsigned q as above. FSM and timing are identical in both builds.
// STRUCTURE
//  Package sc_pkg: sc_state_t enum {IDLE,WARM,ACC,HOLD}; localparams for window length
//   (1<<N) and the SKIP counter width.
//  Sub-module sc_ones_counter: clear/enable/x inputs and an N+1-bit count output.
//   It is reusable by dru variants. Top level holds the FSM, window/skip counters,
//   saturation and the output registers.
// TESTING (N=10, window 1024; chain sng->stanh->decoder plus direct-drive bench)
//  1. x=0 constant, start pulse -> q_valid after 1024 samples, q=0 (bipolar: -512).
//  2. x=1 constant -> q=1023 saturated (bipolar: 511).
//  3. x alternating 1,0 -> q=512 (bipolar: 0). q_valid rises exactly 1024 cycles after the start edge.
//  4. q_ready=0 for 20 cycles in HOLD with start pulsed -> q and q_valid stay stable, no new window.
//     Then q_ready=1 & start=1 -> next window begins and busy rises the next cycle.
//  5. rst=1 at sample 500 of ACC -> next cycle IDLE, q=0, q_valid=0, busy=0.
//     A fresh window afterwards gives a correct count.
//  6. SKIP=4: x=1 for 4 cycles after start, then 0 -> q=0 (warm-up bits excluded).

Source files
------------

// File: rtl/sc_window_decoder_pkg.sv
// sc_pkg: shared types and constants for the windowed stochastic decoder.
//   sc_state_t  - decoder FSM states (IDLE, WARM, ACC, HOLD)
//   N_DEFAULT   - default result width (window = 2^N_DEFAULT cycles)
//   SKIP_W      - width of the warm-up counter (SKIP range 0..255)
//   win_len()   - window length 1<<n for a given result width
package sc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WARM,
        ACC,
        HOLD
    } sc_state_t;

    localparam int N_DEFAULT = 10;
    localparam int SKIP_W    = 8;

    function automatic int win_len(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/sc_window_decoder_if.sv
// sc_window_decoder_if: bitstream input, start request and the q valid/ready
// result channel of the windowed decoder.
//   x        - stochastic bitstream
//   start    - window request (level)
//   busy     - decoder is warming up or accumulating
//   q        - decoded result, N bits
//   q_valid  - result available
//   q_ready  - consumer accepts q
// Modports: master = decoder side, slave = producer/consumer environment.
interface sc_window_decoder_if
    import sc_pkg::*;
#(
    parameter int N = N_DEFAULT
) ();

    logic         x;
    logic         start;
    logic         busy;
    logic [N-1:0] q;
    logic         q_valid;
    logic         q_ready;

    modport master (
        input  x,
        input  start,
        input  q_ready,
        output busy,
        output q,
        output q_valid
    );

    modport slave (
        output x,
        output start,
        output q_ready,
        input  busy,
        input  q,
        input  q_valid
    );

endinterface

// File: rtl/sc_window_decoder_ones_counter.sv
// sc_ones_counter: N+1-bit counter of ones in a bitstream.
//   clk    - rising-edge clock
//   rst    - synchronous active-high reset
//   clear  - synchronous clear (takes priority over enable)
//   en     - add x to the count on this edge
//   x      - stream bit
//   count  - number of ones seen since the last clear (0..2^N)
module sc_ones_counter
    import sc_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       en,
    input  logic       x,
    output logic [N:0] count
);

    // One extra bit so a full window of ones (2^N) is representable.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + {{N{1'b0}}, x};
        end
    end

endmodule

// File: rtl/sc_window_decoder.sv
// sc_window_decoder: windowed stochastic-to-binary decoder.
// On start it drops SKIP warm-up cycles, counts the ones in x over exactly
// 2^N clocks and presents the result on q with a valid/ready handshake.
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - sc_window_decoder_if.master (x, start, busy, q, q_valid, q_ready)
// Parameters: N (result width, window 2^N, N >= 2), SKIP (warm-up, 0..255).
// Build option: define SC_BIPOLAR_EN for a two's complement bipolar q
// (ones - 2^(N-1), saturated); otherwise q = min(ones, 2^N-1).
module sc_window_decoder
    import sc_pkg::*;
#(
    parameter int N    = N_DEFAULT,
    parameter int SKIP = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    sc_window_decoder_if.master   bus
);

    localparam logic [N:0]        WIN_LEN   = (N+1)'(win_len(N));
    localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'((SKIP > 0) ? SKIP - 1 : 0);
    localparam sc_state_t         FIRST     = (SKIP > 0) ? WARM : ACC;

    sc_state_t         state;
    sc_state_t         state_nx;
    logic [N-1:0]      win_cnt;
    logic [SKIP_W-1:0] skip_cnt;
    logic [N:0]        ones;
    logic [N:0]        ones_final;
    logic [N-1:0]      q_nx;
    logic              cnt_clear;
    logic              load_q;
    logic              win_done;
    logic              skip_done;

    sc_ones_counter #(.N(N)) u_ones (
        .clk   (clk),
        .rst   (rst),
        .clear (cnt_clear),
        .en    (state == ACC),
        .x     (bus.x),
        .count (ones)
    );

    assign win_done  = (win_cnt == '1);
    assign skip_done = (skip_cnt == SKIP_LAST);
    assign bus.busy  = (state == WARM) || (state == ACC);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state. Starting a window (from IDLE, or from HOLD together with
    // the handshake) clears the counters so back-to-back windows need no
    // idle bubble.
    always_comb begin
        state_nx  = state;
        cnt_clear = 1'b0;
        load_q    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nx  = FIRST;
                    cnt_clear = 1'b1;
                end
            end
            WARM: begin
                if (skip_done) begin
                    state_nx = ACC;
                end
            end
            ACC: begin
                if (win_done) begin
                    state_nx = HOLD;
                    load_q   = 1'b1;
                end
            end
            HOLD: begin
                if (bus.q_ready) begin
                    if (bus.start) begin
                        state_nx  = FIRST;
                        cnt_clear = 1'b1;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Window and warm-up counters; the window counter reaching all-ones
    // marks the 2^N-th sample.
    always_ff @(posedge clk) begin
        if (rst || cnt_clear) begin
            win_cnt  <= '0;
            skip_cnt <= '0;
        end else begin
            if (state == ACC) begin
                win_cnt <= win_cnt + 1'b1;
            end
            if (state == WARM) begin
                skip_cnt <= skip_cnt + 1'b1;
            end
        end
    end

    // The last sample is taken on the same edge that loads q, so it is added
    // here rather than waiting for the counter to absorb it.
    assign ones_final = ones + {{N{1'b0}}, bus.x};

`ifdef SC_BIPOLAR_EN
    // ones - 2^(N-1) is just the low N bits with the MSB inverted; only the
    // top end (ones = 2^N) can overflow.
    always_comb begin
        q_nx = {~ones_final[N-1], ones_final[N-2:0]};
        if (ones_final >= WIN_LEN) begin
            q_nx = {1'b0, {(N-1){1'b1}}};
        end
    end
`else
    always_comb begin
        q_nx = ones_final[N-1:0];
        if (ones_final >= WIN_LEN) begin
            q_nx = '1;
        end
    end
`endif

    // Output registers: q is held stable until the consumer takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.q       <= '0;
            bus.q_valid <= 1'b0;
        end else if (load_q) begin
            bus.q       <= q_nx;
            bus.q_valid <= 1'b1;
        end else if ((state == HOLD) && bus.q_ready) begin
            bus.q_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sc_window_decoder.sv
// tb_sc_window_decoder: self-checking bench for sc_window_decoder.
// dut0 runs with SKIP=0, dut1 with SKIP=4; both N=10 (window 1024).
module tb_sc_window_decoder;

    localparam int N   = 10;
    localparam int WIN = 1024;

    logic clk = 1'b0;
    logic rst0;
    logic rst1;
    int   compared   = 0;
    int   mismatched = 0;
    int   ones;
    int   last_ones;

    sc_window_decoder_if #(.N(N)) bus0 ();
    sc_window_decoder_if #(.N(N)) bus1 ();

    sc_window_decoder #(.N(N), .SKIP(0)) dut0 (
        .clk (clk),
        .rst (rst0),
        .bus (bus0.master)
    );

    sc_window_decoder #(.N(N), .SKIP(4)) dut1 (
        .clk (clk),
        .rst (rst1),
        .bus (bus1.master)
    );

    always #5 clk = ~clk;

    // Reference: decoded value from the number of ones in a window.
    function automatic logic [N-1:0] expectedQ(input int n_ones);
        int v;
`ifdef SC_BIPOLAR_EN
        v = n_ones - WIN / 2;
        if (v > WIN / 2 - 1) v = WIN / 2 - 1;
`else
        v = n_ones;
        if (v > WIN - 1) v = WIN - 1;
`endif
        return v[N-1:0];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Requests a window on dut0 (also acknowledging any held result) and
    // drives nsamp window bits. Returns after the last bit is driven, before
    // the edge that samples it.
    task automatic applyStimulus(input int pattern, input int pct, input int nsamp, output int n_ones);
        logic b;
        n_ones = 0;
        bus0.start   = 1'b1;
        bus0.q_ready = 1'b1;
        for (int i = 0; i < nsamp; i++) begin
            @(posedge clk); #1;
            bus0.start   = 1'b0;
            bus0.q_ready = 1'b0;
            case (pattern)
                0:       b = 1'b0;
                1:       b = 1'b1;
                2:       b = (i % 2 == 0);
                default: b = ($urandom_range(99) < pct);
            endcase
            bus0.x = b;
            n_ones += int'(b);
            if (i == 0) begin
                checkOutput("busy_after_start", {31'd0, bus0.busy}, 32'd1);
                checkOutput("valid_drop", {31'd0, bus0.q_valid}, 32'd0);
            end
        end
    endtask

    task automatic checkWindow(input string tag, input int n_ones);
        checkOutput({tag, "_valid_early"}, {31'd0, bus0.q_valid}, 32'd0);
        @(posedge clk); #1;
        bus0.x = 1'b0;
        checkOutput({tag, "_valid"}, {31'd0, bus0.q_valid}, 32'd1);
        checkOutput({tag, "_q"}, {22'd0, bus0.q}, {22'd0, expectedQ(n_ones)});
        checkOutput({tag, "_busy_done"}, {31'd0, bus0.busy}, 32'd0);
    endtask

    initial begin
        rst0 = 1'b1;
        rst1 = 1'b1;
        bus0.x = 1'b0; bus0.start = 1'b0; bus0.q_ready = 1'b0;
        bus1.x = 1'b0; bus1.start = 1'b0; bus1.q_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst0 = 1'b0;
        rst1 = 1'b0;

        $display("[TB] reset state");
        checkOutput("rst_q", {22'd0, bus0.q}, 32'd0);
        checkOutput("rst_valid", {31'd0, bus0.q_valid}, 32'd0);
        checkOutput("rst_busy", {31'd0, bus0.busy}, 32'd0);
        checkOutput("rst1_valid", {31'd0, bus1.q_valid}, 32'd0);

        $display("[TB] constant zero window");
        applyStimulus(0, 0, WIN, ones);
        checkWindow("zero", ones);

        $display("[TB] constant one window (back-to-back)");
        applyStimulus(1, 0, WIN, ones);
        checkWindow("ones", ones);

        $display("[TB] alternating window");
        applyStimulus(2, 0, WIN, ones);
        checkWindow("alt", ones);

        $display("[TB] random windows");
        for (int w = 0; w < 3; w++) begin
            applyStimulus(3, int'($urandom_range(95, 5)), WIN, ones);
            checkWindow("rand", ones);
        end
        last_ones = ones;

        $display("[TB] stall in HOLD with start pulses");
        for (int i = 0; i < 20; i++) begin
            bus0.start   = (i % 3 == 0);
            bus0.q_ready = 1'b0;
            @(posedge clk); #1;
        end
        bus0.start = 1'b0;
        checkOutput("stall_q", {22'd0, bus0.q}, {22'd0, expectedQ(last_ones)});
        checkOutput("stall_valid", {31'd0, bus0.q_valid}, 32'd1);
        checkOutput("stall_busy", {31'd0, bus0.busy}, 32'd0);

        $display("[TB] handshake with start after stall");
        applyStimulus(3, 30, WIN, ones);
        checkWindow("after_stall", ones);

        $display("[TB] handshake without start returns to idle");
        bus0.q_ready = 1'b1;
        @(posedge clk); #1;
        bus0.q_ready = 1'b0;
        checkOutput("idle_valid", {31'd0, bus0.q_valid}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("idle_busy", {31'd0, bus0.busy}, 32'd0);

        $display("[TB] reset mid-window");
        applyStimulus(3, 50, 500, ones);
        rst0 = 1'b1;
        @(posedge clk); #1;
        rst0 = 1'b0;
        bus0.x = 1'b0;
        checkOutput("midrst_q", {22'd0, bus0.q}, 32'd0);
        checkOutput("midrst_valid", {31'd0, bus0.q_valid}, 32'd0);
        checkOutput("midrst_busy", {31'd0, bus0.busy}, 32'd0);
        applyStimulus(3, 70, WIN, ones);
        checkWindow("post_rst", ones);

        $display("[TB] warm-up bits excluded (SKIP=4)");
        bus1.start = 1'b1;
        for (int i = 0; i < WIN + 4; i++) begin
            @(posedge clk); #1;
            bus1.start = 1'b0;
            bus1.x     = (i < 4);
            if (i == 0) begin
                checkOutput("skip_busy", {31'd0, bus1.busy}, 32'd1);
            end
        end
        checkOutput("skip_valid_early", {31'd0, bus1.q_valid}, 32'd0);
        @(posedge clk); #1;
        checkOutput("skip_valid", {31'd0, bus1.q_valid}, 32'd1);
        checkOutput("skip_q", {22'd0, bus1.q}, {22'd0, expectedQ(0)});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
